// File: rtl/pc_branch_unit.sv
// Fetch-side control: program counter, status flags, conditional jumps
// and a small CALL/RET return-address stack.
module pc_branch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                flags_we,
  input  logic [3:0]          jump_op,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                call,
  input  logic                ret,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] im_addr,
  output logic [3:0]          flags_out,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [3:0]          r_flags;
  logic [SPW-1:0]      r_sp;
  logic                r_ovf;
  logic                r_unf;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic                w_full;
  logic                w_empty;
  logic [IW-1:0]       w_push_idx;
  logic [IW-1:0]       w_top_idx;
  logic                w_take;
  logic                w_z, w_n, w_c, w_v;
  logic [SPW-1:0]      w_sp_dec;

  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_full     = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_sp_dec   = r_sp - SPW'(1);
  assign w_push_idx = r_sp[IW-1:0];
  assign w_top_idx  = w_sp_dec[IW-1:0];

  // Conditions always see the registered flags, never the live ALU bits
  assign {w_z, w_n, w_c, w_v} = r_flags;

  always_comb begin
    w_take = 1'b0;
    case (jump_op)
      4'd1:    w_take = 1'b1;
      4'd2:    w_take = w_z;
      4'd3:    w_take = ~w_z;
      4'd4:    w_take = ~w_z & ~w_n;
      4'd5:    w_take = w_n;
      4'd6:    w_take = ~w_n;
      4'd7:    w_take = w_z | w_n;
      4'd8:    w_take = w_c;
      4'd9:    w_take = w_v;
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_flags <= '0;
      r_sp    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      if (flags_we)
        r_flags <= {alu_z, alu_n, alu_c, alu_v};
      if (ret) begin
        if (!w_empty) begin
          r_pc <= r_stack[w_top_idx];
          r_sp <= w_sp_dec;
        end else begin
          r_unf <= 1'b1;
          r_pc  <= w_pc_inc;
        end
      end else if (call) begin
        if (!w_full) begin
          r_stack[w_push_idx] <= w_pc_inc;
          r_sp <= r_sp + SPW'(1);
          r_pc <= jump_target;
        end else begin
          r_ovf <= 1'b1;
          r_pc  <= w_pc_inc;
        end
      end else if (w_take) begin
        r_pc <= jump_target;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign im_addr         = r_pc;
  assign flags_out       = r_flags;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: expected fetch addresses are queued
// when each step is driven and compared after the following clock edge.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_z, alu_n, alu_c, alu_v;
  logic       flags_we;
  logic [3:0] jump_op;
  logic [7:0] jump_target;
  logic       call, ret, stall;
  logic [7:0] im_addr;
  logic [3:0] flags_out;
  logic       stack_overflow;
  logic       stack_underflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] m_pc;
  logic [7:0] exp_q[$];

  pc_branch_unit #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_z           (alu_z),
    .alu_n           (alu_n),
    .alu_c           (alu_c),
    .alu_v           (alu_v),
    .flags_we        (flags_we),
    .jump_op         (jump_op),
    .jump_target     (jump_target),
    .call            (call),
    .ret             (ret),
    .stall           (stall),
    .im_addr         (im_addr),
    .flags_out       (flags_out),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; flags_we = 0; jump_op = 0; jump_target = 0;
    call = 0; ret = 0; stall = 0;
    {alu_z, alu_n, alu_c, alu_v} = 4'b0000;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected next address, clock once, then compare it.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, im_addr, e);
    end
    m_pc = exp;
  endtask

  task automatic go(input logic [7:0] tgt);
    idle(); jump_op = 4'd1; jump_target = tgt;
    step("jmp", tgt);
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    step("reset", 8'h00);
    chk("rst_flags", {4'h0, flags_out}, 8'h00);
    chk("rst_ovf", {7'h0, stack_overflow}, 8'h00);
    chk("rst_unf", {7'h0, stack_underflow}, 8'h00);
    idle();
    for (int i = 1; i <= 4; i++) step("freerun", 8'(i));
    // reset during a jump discards the jump
    reset = 1; jump_op = 4'd1; jump_target = 8'h55;
    step("reset_mid", 8'h00);
    chk("reset_mid_flags", {4'h0, flags_out}, 8'h00);
    idle();

    // Z set at pc 14, JEQ at 15
    go(8'd14);
    flags_we = 1; alu_z = 1;
    step("flag_z1", 8'd15);
    chk("flags_z1", {4'h0, flags_out}, 8'h08);
    idle(); jump_op = 4'd2; jump_target = 8'd20;
    step("jeq_taken", 8'd20);
    go(8'd14);
    flags_we = 1; alu_z = 0;
    step("flag_z0", 8'd15);
    chk("flags_z0", {4'h0, flags_out}, 8'h00);
    idle(); jump_op = 4'd2; jump_target = 8'd20;
    step("jeq_not", 8'd16);
    // same-cycle flag write: jump sees the old Z=0
    flags_we = 1; alu_z = 1;
    step("jeq_oldflags", 8'd17);
    chk("flags_new", {4'h0, flags_out}, 8'h08);
    idle(); jump_op = 4'd2; jump_target = 8'd20;
    step("jeq_newflags", 8'd20);

    // flags = 0100 (N only), sweep conditional codes
    idle(); flags_we = 1; alu_n = 1;
    step("flag_n", 8'd21);
    chk("flags_n", {4'h0, flags_out}, 8'h04);
    for (int op = 3; op <= 15; op++) begin
      logic [7:0] exp;
      idle(); jump_op = 4'(op); jump_target = 8'h40;
      exp = (op == 3 || op == 5 || op == 7) ? 8'h40 : m_pc + 8'd1;
      step($sformatf("cond_op%0d", op), exp);
    end

    // CALL / RET, call beats jump_op
    go(8'h10);
    call = 1; jump_op = 4'd1; jump_target = 8'h80;
    step("call", 8'h80);
    idle(); ret = 1;
    step("ret", 8'h11);
    idle(); call = 1;
    jump_target = 8'h20; step("call1", 8'h20);
    jump_target = 8'h30; step("call2", 8'h30);
    jump_target = 8'h40; step("call3", 8'h40);
    jump_target = 8'h50; step("call4", 8'h50);
    chk("no_ovf", {7'h0, stack_overflow}, 8'h00);
    jump_target = 8'h60; step("call5_full", 8'h51);
    chk("ovf", {7'h0, stack_overflow}, 8'h01);
    // ret beats call
    idle(); ret = 1; call = 1; jump_target = 8'h99;
    step("ret4", 8'h41);
    call = 0;
    step("ret3", 8'h31);
    step("ret2", 8'h21);
    step("ret1", 8'h12);

    // RET on empty stack
    go(8'd7);
    ret = 1;
    step("ret_empty", 8'd8);
    chk("unf", {7'h0, stack_underflow}, 8'h01);
    idle();
    step("run", 8'd9);
    chk("unf_sticky", {7'h0, stack_underflow}, 8'h01);
    chk("ovf_sticky", {7'h0, stack_overflow}, 8'h01);

    // CALL at 255 pushes wrapped 0
    go(8'hFF);
    call = 1; jump_target = 8'h90;
    step("call_wrap", 8'h90);
    idle(); ret = 1;
    step("ret_wrap", 8'h00);

    // stall holds pc and flags
    go(8'h30);
    stall = 1; jump_op = 4'd1; jump_target = 8'hA0;
    flags_we = 1; {alu_z, alu_n, alu_c, alu_v} = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step("stall_pc", 8'h30);
      chk("stall_flags", {4'h0, flags_out}, 8'h04);
    end
    stall = 0;
    step("stall_rel", 8'hA0);
    chk("rel_flags", {4'h0, flags_out}, 8'h0F);

    // pc wrap
    go(8'hFF);
    step("wrap", 8'h00);

    // reset clears everything, even with stall asserted
    stall = 1; reset = 1;
    step("reset_end", 8'h00);
    chk("end_flags", {4'h0, flags_out}, 8'h00);
    chk("end_ovf", {7'h0, stack_overflow}, 8'h00);
    chk("end_unf", {7'h0, stack_underflow}, 8'h00);
    idle();
    ret = 1;
    step("ret_after_rst", 8'h01);
    chk("unf_after_rst", {7'h0, stack_underflow}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
